gpp_prog_loader: RTL and testbench
==================================

# gpp_prog_loader

Boot-time program loader for the gpp_calc processor, sitting directly upstream of the core's instruction memory. It accepts a framed byte stream (from a UART receiver or testbench), assembles 16-bit instructions, and writes them sequentially into instruction memory from address 0. It holds the core in reset until a complete, valid image has been written, then releases it.

## Interface
Parameters:
- IM_AW, 10: instruction memory address width; maximum image is 2^IM_AW words.
- SYNC, 8'hA5: frame start byte.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts the byte; a transfer occurs when rx_valid & rx_ready.
- im_wr_en  output  1  instruction memory write strobe, one cycle per word.
- im_wr_addr  output  IM_AW  write address.
- im_wr_data  output  16  instruction word.
- core_hold  output  1  high keeps the core in reset; the top level combines it with rst.
- done  output  1  image loaded and core released.
- err  output  1  framing, length or checksum error; sticky until the next SYNC or reset.
- word_count  output  IM_AW+1  words written in the current frame.

## Operation
- Frame format: SYNC, LEN_H, LEN_L, then LEN words sent high byte first, then a CSUM byte (only when checksum is enabled).
- LEN is 16-bit big-endian. The legal range is 1..2^IM_AW. LEN=0 or LEN>2^IM_AW leads to ERROR.
- FSM states: IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CSUM, RUN, ERROR.
- IDLE: non-SYNC bytes are discarded. SYNC moves to LEN_H.
- LEN_H and LEN_L latch the length. LEN_L moves to DATA_H, or to ERROR if the length is illegal.
- DATA_H latches the high byte.
- DATA_L forms the word {hi, lo} and issues a write at the current address, then increments the address. The FSM returns to DATA_H, or on the last word moves to CSUM (checksum enabled) or RUN.
- CSUM: if the received byte equals the XOR of all data bytes, move to RUN; otherwise move to ERROR.
- RUN: core_hold=0, done=1. Non-SYNC bytes are ignored. SYNC restarts a load: core_hold=1, done=0, address and word_count clear, move to LEN_H.
- ERROR: core_hold=1, err=1. SYNC clears err and moves to LEN_H. Other bytes are ignored.
- rx_ready is 1 in every state after reset. Accepted bytes never stall.
- The address counter is IM_AW wide. The maximum-length frame ends exactly at the last address, so the counter never wraps within a legal frame.
- Words already written by a frame that ends in ERROR remain in memory. The core stays held.

## Timing
- Reset values: rx_ready=0 while rst is low, 1 from the first clock after release. im_wr_en=0, im_wr_addr=0, im_wr_data=0, core_hold=1, done=0, err=0, word_count=0. FSM is in IDLE.
- Reset mid-load aborts immediately. core_hold stays 1.
- im_wr_en, im_wr_addr and im_wr_data are registered. The write appears in the cycle after the DATA_L byte is accepted, held for exactly one cycle.
- word_count updates in the same cycle as the write.
- core_hold falls and done rises in the cycle after the final accepted byte: the last DATA_L byte, or CSUM when checksum is enabled. That final write and the core release occur in the same cycle.
- err rises in the cycle after the offending byte is accepted.
- Maximum throughput: one byte per cycle, so one word every two cycles.

## Configuration
- GPP_LOADER_CHECKSUM_EN defined: the CSUM state and XOR accumulator are present. A checksum mismatch causes ERROR.
- GPP_LOADER_CHECKSUM_EN undefined: no CSUM byte is expected. The last DATA_L transitions directly to RUN, and err can only come from a bad length.

## Structure
- Package gpp_loader_pkg holds:
  - the state enum;
  - SYNC_DEFAULT = 8'hA5;
  - the byte-order convention.
- Sub-module gpp_loader_csum is an 8-bit XOR accumulator with clear, enable and data inputs. It is instantiated only under GPP_LOADER_CHECKSUM_EN.

## Test plan
- Frame A5 00 02 12 34 AB CD (plus CSUM 0x40 when checksum is enabled) → writes 0x1234@0 and 0xABCD@1, word_count=2, core_hold falls in the cycle after the last byte, done=1.
- Noise bytes 00 FF before A5, then a 1-word frame 00 01 DE AD (CSUM 0x73) → noise ignored, a single write of 0xDEAD@0.
- Length 00 00, and separately length 04 01 with IM_AW=10 → err=1, core_hold=1, no writes.
- Checksum enabled, frame A5 00 01 00 01 followed by CSUM 0x00 → write 0x0001@0, then err=1, core_hold stays 1, done=0.
- In RUN, send A5 00 01 55 AA (CSUM 0xFF) → core_hold returns to 1, then a write of 0x55AA@0, then RUN again. rx_valid gaps inserted between bytes do not change the result.
- Assert rst low in the middle of DATA_L → all outputs return to their reset values asynchronously. A following full frame loads correctly from address 0.

Source files
------------

// File: rtl/gpp_loader_pkg.sv
// Shared types for the gpp_calc boot loader: FSM states, default frame sync byte
// and the byte order used to assemble instruction words.
package gpp_loader_pkg;

   typedef enum logic [2:0] {
      IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CSUM, RUN, ERROR
   } loader_state_e;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // Words and lengths travel big-endian: the first byte on the wire is the MSB.
   localparam bit HI_BYTE_FIRST = 1'b1;

   function automatic logic [15:0] make_word(input logic [7:0] first, input logic [7:0] second);
      return HI_BYTE_FIRST ? {first, second} : {second, first};
   endfunction

endpackage

// File: rtl/gpp_loader_csum.sv
// Running XOR of frame data bytes; cleared at frame start, folded on every data byte.
module gpp_loader_csum (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] acc
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= acc ^ din;
   end

endmodule

// File: rtl/gpp_prog_loader.sv
// Framed byte-stream program loader for gpp_calc: fills instruction memory from 0 and holds
// the core until a full image is in. Optional trailing checksum under GPP_LOADER_CHECKSUM_EN.
module gpp_prog_loader
   import gpp_loader_pkg::*;
#(
   parameter int         IM_AW = 10,
   parameter logic [7:0] SYNC  = SYNC_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic             im_wr_en,
   output logic [IM_AW-1:0] im_wr_addr,
   output logic [15:0]      im_wr_data,
   output logic             core_hold,
   output logic             done,
   output logic             err,
   output logic [IM_AW:0]   word_count
);

   localparam logic [16:0]    MAX_LEN = 17'd1 << IM_AW;
   localparam logic [IM_AW:0] WC_ONE  = 1;

   loader_state_e state, state_nxt;
   logic [7:0]  len_h, hi;
   logic [16:0] len_q, len_full;
   logic [IM_AW:0] wc_inc;
   logic take, start, wr, len_ok, last_word, csum_ok;

   assign take      = rx_valid & rx_ready;
   assign len_full  = {1'b0, len_h, rx_data};
   assign len_ok    = (len_full != '0) && (len_full <= MAX_LEN);
   assign wc_inc    = word_count + WC_ONE;
   assign last_word = (17'(wc_inc) == len_q);

`ifdef GPP_LOADER_CHECKSUM_EN
   localparam loader_state_e AFTER_LAST = CSUM;
   logic [7:0] csum;
   logic       data_byte;

   assign data_byte = take && (state == DATA_H || state == DATA_L);

   gpp_loader_csum u_csum (
      .clk (clk),
      .rst (rst),
      .clr (start),
      .en  (data_byte),
      .din (rx_data),
      .acc (csum)
   );

   assign csum_ok = (rx_data == csum);
`else
   localparam loader_state_e AFTER_LAST = RUN;
   assign csum_ok = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      wr        = 1'b0;
      if (take) begin
         case (state)
            IDLE, RUN, ERROR: begin
               if (rx_data == SYNC) begin
                  state_nxt = LEN_H;
                  start     = 1'b1;
               end
            end
            LEN_H:  state_nxt = LEN_L;
            LEN_L:  state_nxt = len_ok ? DATA_H : ERROR;
            DATA_H: state_nxt = DATA_L;
            DATA_L: begin
               wr        = 1'b1;
               state_nxt = last_word ? AFTER_LAST : DATA_H;
            end
            CSUM:    state_nxt = csum_ok ? RUN : ERROR;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         rx_ready   <= 1'b0;
         len_h      <= '0;
         len_q      <= '0;
         hi         <= '0;
         im_wr_en   <= 1'b0;
         im_wr_addr <= '0;
         im_wr_data <= '0;
         word_count <= '0;
      end else begin
         state    <= state_nxt;
         rx_ready <= 1'b1;
         im_wr_en <= wr;
         if (take && state == LEN_H)  len_h <= rx_data;
         if (take && state == LEN_L)  len_q <= len_full;
         if (take && state == DATA_H) hi    <= rx_data;
         // Address is the count of words already written, so a max frame ends on the top word.
         if (wr) begin
            im_wr_addr <= word_count[IM_AW-1:0];
            im_wr_data <= make_word(hi, rx_data);
            word_count <= wc_inc;
         end else if (start) begin
            im_wr_addr <= '0;
            word_count <= '0;
         end
      end
   end

   assign core_hold = (state != RUN);
   assign done      = (state == RUN);
   assign err       = (state == ERROR);

endmodule

// File: tb/tb_gpp_prog_loader.sv
// Directed bench for gpp_prog_loader: frame-level model of expected writes and final status.
module tb_gpp_prog_loader;

   localparam int AW = 10;
`ifdef GPP_LOADER_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_ready, im_wr_en, core_hold, done, err;
   logic [AW-1:0] im_wr_addr;
   logic [15:0]   im_wr_data;
   logic [AW:0]   word_count;

   typedef struct {
      logic [AW-1:0] a;
      logic [15:0]   d;
      logic [AW:0]   wc;
   } wr_t;

   wr_t           exp_q[$];
   logic [15:0]   fw[$];
   logic [AW-1:0] last_a = '0;
   logic [15:0]   last_d = '0;
   int            checks = 0;
   int            errors = 0;

   gpp_prog_loader #(.IM_AW(AW), .SYNC(8'hA5)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .im_wr_en   (im_wr_en),
      .im_wr_addr (im_wr_addr),
      .im_wr_data (im_wr_data),
      .core_hold  (core_hold),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Per-cycle comparison of writes against the expected write queue.
   task automatic monitor();
      wr_t e;
      if (!rst) return;
      chk("done_vs_hold", 32'(done), 32'(!core_hold));
      if (im_wr_en) begin
         last_a = im_wr_addr;
         last_d = im_wr_data;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %h data %h, no write expected", im_wr_addr, im_wr_data);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(im_wr_addr), 32'(e.a));
            chk("wr_data", 32'(im_wr_data), 32'(e.d));
            chk("wr_count", 32'(word_count), 32'(e.wc));
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
      monitor();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b0;
      repeat (gap) tick();
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   // Builds the byte stream for the words in fw, predicts writes and the final status.
   task automatic run_frame(input logic [15:0] len, input int gap, input bit bad_csum);
      logic [7:0] b[$];
      logic [7:0] x;
      bit legal, ok;
      legal = (len != 16'd0) && (int'(len) <= (1 << AW));
      x = 8'h00;
      b.push_back(8'hA5);
      b.push_back(len[15:8]);
      b.push_back(len[7:0]);
      if (legal) begin
         foreach (fw[i]) begin
            b.push_back(fw[i][15:8]);
            b.push_back(fw[i][7:0]);
            x = x ^ fw[i][15:8] ^ fw[i][7:0];
            exp_q.push_back('{a: AW'(i), d: fw[i], wc: (AW+1)'(i + 1)});
         end
         if (CSUM_ON) b.push_back(bad_csum ? (x ^ 8'h01) : x);
      end
      ok = legal && !(bad_csum && CSUM_ON);
      foreach (b[k]) begin
         send_byte(b[k], gap);
         if (k != b.size() - 1) begin
            chk("hold_during_load", 32'(core_hold), 32'd1);
            chk("done_during_load", 32'(done), 32'd0);
            chk("err_during_load", 32'(err), 32'd0);
         end else if (legal && !CSUM_ON) begin
            chk("release_with_last_write", 32'(im_wr_en), 32'd1);
         end
      end
      chk("final_done", 32'(done), 32'(ok));
      chk("final_hold", 32'(core_hold), 32'(!ok));
      chk("final_err", 32'(err), 32'(!ok));
      chk("final_count", 32'(word_count), legal ? 32'(len) : 32'd0);
      chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Reset state
      tick();
      chk("rst_ready", 32'(rx_ready), 32'd0);
      chk("rst_hold", 32'(core_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_wr_en", 32'(im_wr_en), 32'd0);
      chk("rst_count", 32'(word_count), 32'd0);
      rst = 1'b1;
      #1 chk("ready_before_clock", 32'(rx_ready), 32'd0);
      tick();
      chk("ready_after_clock", 32'(rx_ready), 32'd1);

      // Two-word frame
      fw = '{16'h1234, 16'hABCD};
      run_frame(16'd2, 0, 1'b0);
      chk("f1_count", 32'(word_count), 32'd2);
      chk("f1_last_addr", 32'(last_a), 32'd1);
      chk("f1_last_data", 32'(last_d), 32'h0000ABCD);

      // Noise before sync is ignored
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      chk("noise_done", 32'(done), 32'd1);
      fw = '{16'hDEAD};
      run_frame(16'd1, 0, 1'b0);
      chk("f2_last_addr", 32'(last_a), 32'd0);
      chk("f2_last_data", 32'(last_d), 32'h0000DEAD);

      // Illegal lengths
      fw = '{};
      run_frame(16'h0000, 0, 1'b0);
      run_frame(16'h0401, 0, 1'b0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 1);
      chk("err_sticky", 32'(err), 32'd1);
      chk("err_hold", 32'(core_hold), 32'd1);

`ifdef GPP_LOADER_CHECKSUM_EN
      // Checksum mismatch keeps the written word but errors out
      fw = '{16'h0001};
      run_frame(16'd1, 0, 1'b1);
      chk("bad_csum_data", 32'(last_d), 32'h00000001);
`endif

      // Maximum-length image
      fw = '{};
      for (int i = 0; i < (1 << AW); i++) fw.push_back(16'(i * 257) ^ 16'h5A3C);
      run_frame(16'h0400, 0, 1'b0);
      chk("max_last_addr", 32'(last_a), 32'h3FF);
      chk("max_count", 32'(word_count), 32'd1024);

      // Reload from RUN with valid gaps
      fw = '{16'h55AA};
      run_frame(16'd1, 2, 1'b0);
      chk("reload_data", 32'(last_d), 32'h000055AA);
      chk("reload_addr", 32'(last_a), 32'd0);

      // Reset in the middle of a data word
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      exp_q.push_back('{a: AW'(0), d: 16'h1122, wc: (AW+1)'(1)});
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      chk("pre_reset_count", 32'(word_count), 32'd1);
      rx_valid = 1'b1;
      rx_data  = 8'h44;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(rx_ready), 32'd0);
      chk("mid_rst_wr_en", 32'(im_wr_en), 32'd0);
      chk("mid_rst_addr", 32'(im_wr_addr), 32'd0);
      chk("mid_rst_data", 32'(im_wr_data), 32'd0);
      chk("mid_rst_hold", 32'(core_hold), 32'd1);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      chk("mid_rst_count", 32'(word_count), 32'd0);
      chk("mid_rst_outstanding", 32'(exp_q.size()), 32'd0);
      rx_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("post_rst_ready", 32'(rx_ready), 32'd1);
      fw = '{16'h1234, 16'hABCD};
      run_frame(16'd2, 0, 1'b0);
      chk("post_rst_last_data", 32'(last_d), 32'h0000ABCD);
      chk("post_rst_last_addr", 32'(last_a), 32'd1);

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
